// File: rtl/cdb_nport.sv
// Multi-lane registered Common Data Bus: one max-priority unit plus N_SRC round-robin sources
// broadcast through N_LANES output registers that hold until the ROB accepts them.
module cdb_nport #(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned N_LANES = 2,
  parameter type         cdb_data_t = logic [31:0]
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  input  logic               max_prio_valid_i,
  output logic               max_prio_ready_o,
  input  cdb_data_t          max_prio_data_i,
  input  logic [N_SRC-1:0]   rs_valid_i,
  output logic [N_SRC-1:0]   rs_ready_o,
  input  cdb_data_t          rs_data_i [N_SRC],
  input  logic [N_LANES-1:0] rob_ready_i,
  output logic [N_LANES-1:0] valid_o,
  output cdb_data_t          data_o [N_LANES]
);

  localparam int unsigned PtrW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PtrW-1:0]    ptr_q, ptr_d;
  logic [N_LANES-1:0] valid_q, valid_d;
  cdb_data_t          data_q [N_LANES];
  cdb_data_t          data_d [N_LANES];

  logic [N_LANES-1:0] lane_free;
  logic [N_LANES-1:0] lane_load;
  int unsigned        lane_rank [N_LANES];
  int unsigned        free_cnt;
  int unsigned        rs_room;
  int unsigned        mp_slots;
  int unsigned        ptr_u;
  logic               mp_grant;
  logic [N_SRC-1:0]   src_grant;
  int unsigned        src_pos   [N_SRC];
  int unsigned        src_ahead [N_SRC];
  int unsigned        last_idx;
  int unsigned        last_pos;
  int unsigned        ptr_nxt;

  // Free lanes are ranked in ascending lane order; a grant with slot n lands in the lane of rank n.
  always_comb begin
    free_cnt = 0;
    for (int unsigned l = 0; l < N_LANES; l++) begin
      lane_free[l] = !valid_q[l] || rob_ready_i[l];
      lane_rank[l] = free_cnt;
      if (lane_free[l]) free_cnt = free_cnt + 1;
    end
  end

  always_comb begin
    ptr_u    = {{(32 - PtrW){1'b0}}, ptr_q};
    mp_grant = !flush_i && max_prio_valid_i && (free_cnt != 0);
    mp_slots = mp_grant ? 1 : 0;
    rs_room  = flush_i ? 0 : (free_cnt - mp_slots);

    // Scan position of each source relative to the round-robin pointer.
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (i >= ptr_u) src_pos[i] = i - ptr_u;
      else            src_pos[i] = i + N_SRC - ptr_u;
    end

    for (int unsigned i = 0; i < N_SRC; i++) begin
      src_ahead[i] = 0;
      for (int unsigned j = 0; j < N_SRC; j++) begin
        if (rs_valid_i[j] && (src_pos[j] < src_pos[i])) src_ahead[i] = src_ahead[i] + 1;
      end
      src_grant[i] = rs_valid_i[i] && (src_ahead[i] < rs_room);
    end

    last_idx = 0;
    last_pos = 0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (src_grant[i] && (src_pos[i] >= last_pos)) begin
        last_pos = src_pos[i];
        last_idx = i;
      end
    end
    ptr_nxt = (last_idx + 1 == N_SRC) ? 0 : last_idx + 1;

    if (flush_i)         ptr_d = '0;
    else if (|src_grant) ptr_d = PtrW'(ptr_nxt);
    else                 ptr_d = ptr_q;
  end

  always_comb begin
    for (int unsigned l = 0; l < N_LANES; l++) begin
      lane_load[l] = 1'b0;
      data_d[l]    = data_q[l];
      if (lane_free[l] && mp_grant && (lane_rank[l] == 0)) begin
        lane_load[l] = 1'b1;
        data_d[l]    = max_prio_data_i;
      end
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (lane_free[l] && src_grant[i] && (src_ahead[i] + mp_slots == lane_rank[l])) begin
          lane_load[l] = 1'b1;
          data_d[l]    = rs_data_i[i];
        end
      end
      valid_d[l] = !flush_i && (lane_load[l] || (valid_q[l] && !rob_ready_i[l]));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      ptr_q   <= '0;
      for (int unsigned l = 0; l < N_LANES; l++) data_q[l] <= '0;
    end else begin
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      for (int unsigned l = 0; l < N_LANES; l++) data_q[l] <= data_d[l];
    end
  end

  // Readies are forced low while reset is held, independent of the clock.
  assign max_prio_ready_o = rst_n_i && mp_grant;
  assign rs_ready_o       = {N_SRC{rst_n_i}} & src_grant;
  assign valid_o          = valid_q;
  assign data_o           = data_q;

endmodule

// File: tb/tb_cdb_nport.sv
// Randomized bench for cdb_nport against a queue-based lane/pointer reference model.
module tb_cdb_nport;

  localparam int N_SRC     = 4;
  localparam int N_LANES   = 2;
  localparam int FairBound = (N_SRC + N_LANES - 1) / N_LANES - 1;

  typedef logic [31:0] data_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               mp_valid;
  logic               mp_ready;
  data_t              mp_data;
  logic [N_SRC-1:0]   rs_valid;
  logic [N_SRC-1:0]   rs_ready;
  data_t              rs_data [N_SRC];
  logic [N_LANES-1:0] rob_ready;
  logic [N_LANES-1:0] valid_out;
  data_t              data_out [N_LANES];

  always #5 clk = ~clk;

  cdb_nport #(
    .N_SRC  (N_SRC),
    .N_LANES(N_LANES)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .flush_i         (flush),
    .max_prio_valid_i(mp_valid),
    .max_prio_ready_o(mp_ready),
    .max_prio_data_i (mp_data),
    .rs_valid_i      (rs_valid),
    .rs_ready_o      (rs_ready),
    .rs_data_i       (rs_data),
    .rob_ready_i     (rob_ready),
    .valid_o         (valid_out),
    .data_o          (data_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit [N_LANES-1:0] m_valid, nx_valid;
  data_t            m_data  [N_LANES];
  data_t            nx_data [N_LANES];
  int               m_ptr, nx_ptr;
  bit               e_mp;
  logic [N_SRC-1:0] e_rs;
  int               last_grant [N_SRC];

  task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: free lanes as an ordered queue, consumed by the max-priority unit first,
  // then by valid sources visited from the pointer in ascending order.
  task automatic model_eval();
    int free_q[$];
    int l;
    int s;
    e_mp     = 1'b0;
    e_rs     = '0;
    nx_valid = m_valid;
    nx_data  = m_data;
    nx_ptr   = m_ptr;
    for (int i = 0; i < N_LANES; i++) begin
      if (!m_valid[i] || rob_ready[i]) free_q.push_back(i);
      if (rob_ready[i]) nx_valid[i] = 1'b0;
    end
    if (flush) begin
      nx_valid = '0;
      nx_ptr   = 0;
      return;
    end
    if (mp_valid && free_q.size() > 0) begin
      l           = free_q.pop_front();
      e_mp        = 1'b1;
      nx_valid[l] = 1'b1;
      nx_data[l]  = mp_data;
    end
    for (int k = 0; k < N_SRC; k++) begin
      if (free_q.size() == 0) break;
      s = (m_ptr + k) % N_SRC;
      if (rs_valid[s]) begin
        l           = free_q.pop_front();
        e_rs[s]     = 1'b1;
        nx_valid[l] = 1'b1;
        nx_data[l]  = rs_data[s];
        nx_ptr      = (s + 1) % N_SRC;
      end
    end
  endtask

  task automatic apply(bit mpv, logic [N_SRC-1:0] rsv, logic [N_LANES-1:0] rob, bit fl);
    @(negedge clk);
    mp_valid  = mpv;
    rs_valid  = rsv;
    rob_ready = rob;
    flush     = fl;
    mp_data   = $urandom;
    for (int i = 0; i < N_SRC; i++) rs_data[i] = $urandom;
    #1;
    model_eval();
    check_eq("mp_ready", {63'd0, mp_ready}, {63'd0, e_mp});
    check_eq("rs_ready", {60'd0, rs_ready}, {60'd0, e_rs});
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    m_valid = nx_valid;
    m_data  = nx_data;
    m_ptr   = nx_ptr;
    check_eq("valid_o", {62'd0, valid_out}, {62'd0, m_valid});
    for (int l = 0; l < N_LANES; l++) begin
      if (m_valid[l]) check_eq($sformatf("data_o[%0d]", l), {32'd0, data_out[l]}, {32'd0, m_data[l]});
    end
  endtask

  // Reset asserted between edges while inputs stay active.
  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    check_eq("rst_valid", {62'd0, valid_out}, 64'd0);
    check_eq("rst_mp_ready", {63'd0, mp_ready}, 64'd0);
    check_eq("rst_rs_ready", {60'd0, rs_ready}, 64'd0);
    @(posedge clk);
    #1;
    check_eq("rst_hold_valid", {62'd0, valid_out}, 64'd0);
    rst_n   = 1'b1;
    m_valid = '0;
    m_ptr   = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    data_t d_mp;
    data_t d_s0;
    logic [N_SRC-1:0]   rv;
    logic [N_LANES-1:0] rb;
    int phase;

    rst_n     = 1'b0;
    flush     = 1'b0;
    mp_valid  = 1'b1;
    mp_data   = '0;
    rs_valid  = '1;
    rob_ready = '1;
    for (int i = 0; i < N_SRC; i++) rs_data[i] = '0;
    m_valid = '0;
    m_ptr   = 0;
    for (int l = 0; l < N_LANES; l++) m_data[l] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_valid", {62'd0, valid_out}, 64'd0);
    check_eq("reset_data0", {32'd0, data_out[0]}, 64'd0);
    check_eq("reset_data1", {32'd0, data_out[1]}, 64'd0);
    check_eq("reset_mp_ready", {63'd0, mp_ready}, 64'd0);
    check_eq("reset_rs_ready", {60'd0, rs_ready}, 64'd0);
    rst_n = 1'b1;

    // Max priority plus round robin from ptr=0.
    apply(1'b1, 4'b1111, 2'b11, 1'b0);
    check_eq("dir_mp_ready", {63'd0, mp_ready}, 64'd1);
    check_eq("dir_rs_ready", {60'd0, rs_ready}, 64'h1);
    d_mp = mp_data;
    d_s0 = rs_data[0];
    advance();
    check_eq("dir_lane0", {32'd0, data_out[0]}, {32'd0, d_mp});
    check_eq("dir_lane1", {32'd0, data_out[1]}, {32'd0, d_s0});

    // Flush with both lanes valid: no readies, lanes clear, pointer back to 0.
    apply(1'b1, 4'b1111, 2'b11, 1'b1);
    check_eq("flush_mp_ready", {63'd0, mp_ready}, 64'd0);
    check_eq("flush_rs_ready", {60'd0, rs_ready}, 64'd0);
    advance();
    check_eq("flush_valid", {62'd0, valid_out}, 64'd0);

    // Rotation: {0,1}, {2,3}, {0,1}.
    apply(1'b0, 4'b1111, 2'b11, 1'b0);
    check_eq("rot0", {60'd0, rs_ready}, 64'h3);
    advance();
    apply(1'b0, 4'b1111, 2'b11, 1'b0);
    check_eq("rot1", {60'd0, rs_ready}, 64'hC);
    advance();
    apply(1'b0, 4'b1111, 2'b11, 1'b0);
    check_eq("rot2", {60'd0, rs_ready}, 64'h3);
    advance();

    // Backpressure on lane1; src2 takes lane0 and moves ptr to 3.
    apply(1'b0, 4'b0100, 2'b01, 1'b0);
    check_eq("bp_src2", {60'd0, rs_ready}, 64'h4);
    advance();
    // Wrap: src3 first, then src1.
    apply(1'b0, 4'b1010, 2'b01, 1'b0);
    check_eq("wrap_src3", {60'd0, rs_ready}, 64'h8);
    advance();
    apply(1'b0, 4'b1010, 2'b01, 1'b0);
    check_eq("wrap_src1", {60'd0, rs_ready}, 64'h2);
    advance();
    // Full hold: nothing free.
    apply(1'b1, 4'b1111, 2'b00, 1'b0);
    check_eq("hold_mp_ready", {63'd0, mp_ready}, 64'd0);
    check_eq("hold_rs_ready", {60'd0, rs_ready}, 64'd0);
    advance();
    check_eq("hold_valid", {62'd0, valid_out}, 64'h3);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      phase = (cyc / 100) % 4;
      if (cyc % 100 == 0) begin
        for (int i = 0; i < N_SRC; i++) last_grant[i] = -1;
      end
      if (phase == 3) begin
        apply(1'b0, '1, '1, 1'b0);
        for (int i = 0; i < N_SRC; i++) begin
          if (rs_ready[i]) begin
            if (last_grant[i] >= 0) begin
              check_eq("fairness", {63'd0, (cyc - last_grant[i] - 1) <= FairBound}, 64'd1);
            end
            last_grant[i] = cyc;
          end
        end
        advance();
      end else begin
        rv = N_SRC'($urandom);
        rb = N_LANES'($urandom | (phase == 1 ? $urandom : 32'd0));
        apply(1'($urandom_range(0, 1)), rv, rb, ($urandom_range(0, 29) == 0));
        if ($urandom_range(0, 249) == 0) reset_mid();
        else advance();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
